cdr_8b10b_pattern_trigger: RTL and testbench

- Parametrised 8B/10B trigger engine for the CDR trigger path, downstream of the per-lane Decode8b10b outputs.
- Matches a masked multi-symbol data/control pattern, or disparity/symbol errors, across LANES decoded symbols per cycle.
- Patterns may straddle cycle boundaries.
- Adds arm/disarm, one-shot, holdoff and a saturating hit counter.

---
 rtl/cdr_8b10b_pattern_trigger.sv | 181 ++++++++++++++++++
 tb/tb_cdr_8b10b_pattern_trigger.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_8b10b_pattern_trigger.sv
// Purpose: masked multi-symbol 8B/10B pattern / error trigger with arm, one-shot, holdoff and hit counter.
// Latency: trig_out/trig_lane registered, one cycle after the valid cycle holding the hit's last symbol.
// Backpressure: none; the decoded symbol stream is never stalled, idle cycles are marked by sym_valid=0.
module cdr_8b10b_pattern_trigger #(
  parameter int LANES         = 4,
  parameter int PATTERN_LEN   = 10,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sym_valid,
  input  logic [8*LANES-1:0]         sym_data,
  input  logic [LANES-1:0]           sym_is_ctl,
  input  logic [LANES-1:0]           sym_disp_err,
  input  logic [LANES-1:0]           sym_err,
  input  logic                       locked,
  input  logic [1:0]                 cfg_mode,
  input  logic [8*PATTERN_LEN-1:0]   cfg_pattern,
  input  logic [PATTERN_LEN-1:0]     cfg_type,
  input  logic [PATTERN_LEN-1:0]     cfg_mask,
  input  logic [HOLDOFF_WIDTH-1:0]   cfg_holdoff,
  input  logic                       cfg_oneshot,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic                       clear_count,
  output logic                       trig_out,
  output logic [$clog2(LANES)-1:0]   trig_lane,
  output logic                       armed,
  output logic [COUNT_WIDTH-1:0]     trig_count
);

  localparam int HIST = PATTERN_LEN - 1;      // history depth in symbols
  localparam int WIN  = HIST + LANES;         // history plus the current cycle
  localparam int FW   = $clog2(WIN + 1);
  localparam int LW   = $clog2(LANES);

  typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_HOLDOFF} state_t;

  state_t                   state, state_nxt;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt, hold_nxt;
  logic                     fire;

  logic [HIST-1:0][7:0]     hist_dat;
  logic [HIST-1:0]          hist_ctl;
  logic [FW-1:0]            fill;

  // Window index 0 is the oldest history symbol; current lane l sits at HIST+l.
  logic [WIN-1:0][7:0]      win_dat;
  logic [WIN-1:0]           win_ctl;

  logic [LANES-1:0]         pat_hit, err_hit, cand;
  logic                     hit;
  logic [LW-1:0]            hit_lane;

  assign win_dat = {sym_data, hist_dat};
  assign win_ctl = {sym_is_ctl, hist_ctl};

  // History shift register and fill level; losing lock invalidates all stored symbols.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_dat <= '0;
      hist_ctl <= '0;
      fill     <= '0;
    end else begin
      if (sym_valid) begin
        hist_dat <= win_dat[WIN-1:LANES];
        hist_ctl <= win_ctl[WIN-1:LANES];
      end
      if (!locked)
        fill <= '0;
      else if (sym_valid)
        fill <= (int'(fill) + LANES >= HIST) ? FW'(HIST) : fill + FW'(LANES);
    end
  end

  // Candidate k ends the pattern on lane k, so pattern symbol j lands on window index k+j.
  always_comb begin
    pat_hit = '0;
    for (int k = 0; k < LANES; k++) begin
      pat_hit[k] = |cfg_mask;
      for (int j = 0; j < PATTERN_LEN; j++) begin
        if (cfg_mask[j]) begin
          if (win_dat[k+j] != cfg_pattern[8*j +: 8] || win_ctl[k+j] != cfg_type[j])
            pat_hit[k] = 1'b0;
          // Unfilled history slots are the oldest ones.
          if (k + j < HIST - int'(fill))
            pat_hit[k] = 1'b0;
        end
      end
    end
  end

  // Error-mode candidates select the per-lane flag(s) chosen by cfg_mode.
  always_comb begin
    err_hit = '0;
    case (cfg_mode)
      2'd1:    err_hit = sym_disp_err;
      2'd2:    err_hit = sym_err;
      2'd3:    err_hit = sym_disp_err | sym_err;
      default: err_hit = '0;
    endcase
  end

  assign cand = (sym_valid && locked) ? ((cfg_mode == 2'd0) ? pat_hit : err_hit) : '0;
  assign hit  = |cand;

  // Lowest matching lane wins when several candidates hit together.
  always_comb begin
    hit_lane = '0;
    for (int k = LANES - 1; k >= 0; k--)
      if (cand[k]) hit_lane = LW'(k);
  end

  // FSM state and holdoff counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_DISARMED;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next state: disarm overrides everything; holdoff counts valid cycles only.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    fire      = 1'b0;
    if (disarm) begin
      state_nxt = S_DISARMED;
    end else begin
      case (state)
        S_DISARMED: if (arm) state_nxt = S_ARMED;
        S_ARMED: begin
          if (hit) begin
            fire = 1'b1;
            if (cfg_oneshot) begin
              state_nxt = S_DISARMED;
            end else if (cfg_holdoff != '0) begin
              hold_nxt  = cfg_holdoff;
              state_nxt = S_HOLDOFF;
            end
          end
        end
        S_HOLDOFF: begin
          if (sym_valid) begin
            hold_nxt = hold_cnt - HOLDOFF_WIDTH'(1);
            if (hold_cnt == HOLDOFF_WIDTH'(1)) state_nxt = S_ARMED;
          end
        end
        default: state_nxt = S_DISARMED;
      endcase
    end
  end

  assign armed = (state != S_DISARMED);

  // Registered trigger pulse; trig_lane keeps the lane of the most recent hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_out  <= 1'b0;
      trig_lane <= '0;
    end else begin
      trig_out <= fire;
      if (fire) trig_lane <= hit_lane;
    end
  end

  // Saturating hit counter; clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      trig_count <= '0;
    else if (clear_count)
      trig_count <= '0;
    else if (fire && trig_count != '1)
      trig_count <= trig_count + COUNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_cdr_8b10b_pattern_trigger.sv
module tb_cdr_8b10b_pattern_trigger;

  localparam int LANES = 4;
  localparam int PL    = 10;
  localparam int HW    = 16;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [31:0] P_DAT = 32'h0000_B5BC;  // lane0 BC K, lane1 B5 D
  localparam logic [3:0]  P_CTL = 4'b0001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sym_valid;
  logic [8*LANES-1:0] sym_data;
  logic [LANES-1:0] sym_is_ctl, sym_disp_err, sym_err;
  logic             locked;
  logic [1:0]       cfg_mode;
  logic [8*PL-1:0]  cfg_pattern;
  logic [PL-1:0]    cfg_type, cfg_mask;
  logic [HW-1:0]    cfg_holdoff;
  logic             cfg_oneshot, arm, disarm, clear_count;
  logic             trig_out;
  logic [1:0]       trig_lane;
  logic             armed;
  logic [CW-1:0]    trig_count;

  cdr_8b10b_pattern_trigger #(
    .LANES(LANES), .PATTERN_LEN(PL), .HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_is_ctl(sym_is_ctl), .sym_disp_err(sym_disp_err), .sym_err(sym_err),
    .locked(locked), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
    .cfg_type(cfg_type), .cfg_mask(cfg_mask), .cfg_holdoff(cfg_holdoff),
    .cfg_oneshot(cfg_oneshot), .arm(arm), .disarm(disarm),
    .clear_count(clear_count), .trig_out(trig_out), .trig_lane(trig_lane),
    .armed(armed), .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses;

  // Reference model: symbol stream since lock, trigger flags, counts.
  byte unsigned q_dat[$];
  bit           q_ctl[$];
  bit           m_armed;
  int           m_hold;
  int           m_count;
  bit           m_trig;
  int           m_lane;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q_dat.delete();
    q_ctl.delete();
    m_armed = 0; m_hold = 0; m_count = 0; m_trig = 0; m_lane = 0;
  endfunction

  // Look for the pattern ending on each current lane in the stream received since lock.
  function automatic void model_hit(output bit hit, output int lane);
    int n, p;
    bit ok, c;
    byte unsigned d;
    hit = 0;
    lane = 0;
    n = q_dat.size();
    for (int k = LANES - 1; k >= 0; k--) begin
      if (cfg_mode == 2'd0) begin
        ok = (cfg_mask != 0);
        for (int j = 0; j < PL; j++) begin
          if (cfg_mask[j]) begin
            p = n + k - (PL - 1) + j;
            if (p < 0) ok = 0;
            else begin
              if (p < n) begin d = q_dat[p]; c = q_ctl[p]; end
              else begin d = sym_data[8*(p-n) +: 8]; c = sym_is_ctl[p-n]; end
              if (d != cfg_pattern[8*j +: 8] || c != cfg_type[j]) ok = 0;
            end
          end
        end
      end else begin
        ok = (cfg_mode[0] && sym_disp_err[k]) || (cfg_mode[1] && sym_err[k]);
      end
      if (ok && sym_valid && locked) begin hit = 1; lane = k; end
    end
  endfunction

  // Advance model and DUT one clock, then compare every output.
  task automatic step();
    bit hit, fire;
    int lane;
    model_hit(hit, lane);
    fire = 0;
    if (disarm) begin
      m_armed = 0; m_hold = 0;
    end else if (!m_armed) begin
      if (arm) m_armed = 1;
    end else if (m_hold == 0) begin
      if (hit) begin
        fire = 1;
        if (cfg_oneshot) m_armed = 0;
        else m_hold = int'(cfg_holdoff);
      end
    end else if (sym_valid) begin
      m_hold--;
    end
    if (!locked) begin
      q_dat.delete(); q_ctl.delete();
    end else if (sym_valid) begin
      for (int l = 0; l < LANES; l++) begin
        q_dat.push_back(sym_data[8*l +: 8]);
        q_ctl.push_back(sym_is_ctl[l]);
      end
      while (q_dat.size() > PL - 1) begin
        void'(q_dat.pop_front());
        void'(q_ctl.pop_front());
      end
    end
    if (clear_count) m_count = 0;
    else if (fire && m_count != CMAX) m_count++;
    m_trig = fire;
    if (fire) m_lane = lane;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("trig_out", trig_out, m_trig);
    check_eq("trig_lane", trig_lane, m_lane);
    check_eq("armed", armed, m_armed);
    check_eq("trig_count", trig_count, m_count);
    arm = 0; disarm = 0; clear_count = 0;
  endtask

  task automatic drive(input logic [31:0] dat, input logic [3:0] ctl);
    sym_valid = 1; locked = 1; sym_data = dat; sym_is_ctl = ctl;
    sym_disp_err = '0; sym_err = '0;
  endtask

  task automatic idle();
    sym_valid = 0; sym_data = '0; sym_is_ctl = '0; sym_disp_err = '0; sym_err = '0;
  endtask

  task automatic set_pattern_cfg(input logic [HW-1:0] hold, input logic oneshot);
    cfg_mode = 2'd0;
    cfg_pattern = '0;
    cfg_pattern[8*8 +: 8] = 8'hBC;
    cfg_pattern[8*9 +: 8] = 8'hB5;
    cfg_type = 10'b01_0000_0000;
    cfg_mask = 10'b11_0000_0000;
    cfg_holdoff = hold;
    cfg_oneshot = oneshot;
  endtask

  task automatic random_segment(input int ncyc);
    disarm = 1; idle(); step();
    cfg_mode = 2'($urandom_range(0, 3));
    cfg_mask = PL'($urandom) & PL'($urandom) & PL'($urandom);
    cfg_type = PL'($urandom);
    for (int j = 0; j < PL; j++)
      cfg_pattern[8*j +: 8] = ($urandom_range(0, 1) == 1) ? 8'hBC : 8'hB5;
    cfg_holdoff = HW'($urandom_range(0, 4));
    cfg_oneshot = ($urandom_range(0, 4) == 0);
    arm = 1; step();
    for (int i = 0; i < ncyc; i++) begin
      sym_valid = ($urandom_range(0, 7) != 0);
      locked = ($urandom_range(0, 15) != 0);
      for (int l = 0; l < LANES; l++)
        sym_data[8*l +: 8] = ($urandom_range(0, 1) == 1) ? 8'hBC : 8'hB5;
      sym_is_ctl = 4'($urandom);
      sym_disp_err = 4'($urandom) & 4'($urandom);
      sym_err = 4'($urandom) & 4'($urandom);
      arm = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      clear_count = ($urandom_range(0, 29) == 0);
      step();
    end
  endtask

  initial begin
    rst_n = 0; arm = 0; disarm = 0; clear_count = 0; locked = 0;
    idle();
    set_pattern_cfg(16'd0, 1'b0);
    model_reset();
    #1;
    check_eq("rst_trig_out", trig_out, 0);
    check_eq("rst_trig_lane", trig_lane, 0);
    check_eq("rst_armed", armed, 0);
    check_eq("rst_trig_count", trig_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1: two-symbol pattern inside one cycle
    arm = 1; step();
    drive(P_DAT, P_CTL); step();
    check_eq("t1_pulse", trig_out, 1);
    check_eq("t1_lane", trig_lane, 1);
    check_eq("t1_count", trig_count, 1);
    idle(); step();
    check_eq("t1_one_cycle", trig_out, 0);

    // 2: pattern straddling two cycles, then broken by loss of lock
    drive(32'hBC00_0000, 4'b1000); step();
    drive(32'h0000_00B5, 4'b0000); step();
    check_eq("t2_pulse", trig_out, 1);
    check_eq("t2_lane", trig_lane, 0);
    check_eq("t2_count", trig_count, 2);
    drive(32'hBC00_0000, 4'b1000); step();
    idle(); locked = 0; step();
    drive(32'h0000_00B5, 4'b0000); step();
    check_eq("t2_unlock_nopulse", trig_out, 0);

    // 3: two hits in one cycle collapse to one
    drive(32'hB5BC_B5BC, 4'b0101); step();
    check_eq("t3_lane", trig_lane, 1);
    check_eq("t3_count", trig_count, 3);

    // 4: holdoff of 3 valid cycles
    disarm = 1; idle(); step();
    set_pattern_cfg(16'd3, 1'b0);
    arm = 1; step();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(P_DAT, P_CTL); step();
      pulses += int'(trig_out);
    end
    check_eq("t4_pulses", pulses, 3);
    check_eq("t4_count", trig_count, 6);
    check_eq("t4_armed", armed, 1);

    // 5: one-shot disparity-error trigger
    disarm = 1; idle(); step();
    cfg_mode = 2'd1; cfg_oneshot = 1; cfg_holdoff = '0;
    arm = 1; step();
    drive(32'h0, 4'b0); sym_disp_err = 4'b0100; step();
    check_eq("t5_lane", trig_lane, 2);
    check_eq("t5_armed", armed, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 4'b0); sym_disp_err = 4'b0100; step();
      pulses += int'(trig_out);
    end
    check_eq("t5_no_rearm", pulses, 0);

    // 6: disarm priority, saturation, clear priority, async reset in holdoff
    idle(); set_pattern_cfg(16'd0, 1'b0);
    arm = 1; step();
    drive(P_DAT, P_CTL); disarm = 1; step();
    check_eq("t6_disarm_nopulse", trig_out, 0);
    check_eq("t6_disarm_count", trig_count, 7);
    arm = 1; idle(); step();
    for (int i = 0; i < 25; i++) begin
      drive(P_DAT, P_CTL); step();
    end
    check_eq("t6_sat_pulse", trig_out, 1);
    check_eq("t6_sat_count", trig_count, CMAX);
    drive(P_DAT, P_CTL); clear_count = 1; step();
    check_eq("t6_clear_count", trig_count, 0);
    disarm = 1; idle(); step();
    cfg_holdoff = 16'd5;
    arm = 1; step();
    drive(P_DAT, P_CTL); step();
    rst_n = 0;
    #1;
    check_eq("t6_rst_trig_out", trig_out, 0);
    check_eq("t6_rst_trig_lane", trig_lane, 0);
    check_eq("t6_rst_armed", armed, 0);
    check_eq("t6_rst_count", trig_count, 0);
    model_reset();
    idle(); locked = 0;
    @(posedge clk);
    #1 rst_n = 1;

    // Randomized segments against the reference model
    for (int s = 0; s < 6; s++) random_segment(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
